// File: rtl/echo_requester.sv
// Initiator side of the echo request/indication protocol: issues numbered say
// requests one at a time, checks each heard indication and keeps run statistics.
`timescale 1ns/1ps
module echo_requester #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [31:0] V_SEED  = 32'h1000,
  parameter logic [31:0] V_STEP  = 32'h0101
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start__ENA,
  input  logic [31:0] start_count,
  output logic        start__RDY,
  output logic        request_say__ENA,
  output logic [31:0] request_say_meth,
  output logic [31:0] request_say_v,
  input  logic        request_say__RDY,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_meth,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  input  logic        rule_enable,
  output logic        rule_ready,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] pass_count,
  output logic [31:0] fail_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] index_q, index_d;
  logic [31:0] count_q, count_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] exp_meth_q, exp_meth_d;
  logic [31:0] exp_v_q, exp_v_d;
  logic [31:0] pass_q, pass_d;
  logic [31:0] fail_q, fail_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;

  logic [31:0] v_cur;
  logic        start_fire;
  logic        say_fire;
  logic        heard_fire;
  logic        heard_match;
  logic        last_req;
  logic        tmo_hit;

  // v is a pure function of the index; the product wraps modulo 2^32.
  assign v_cur       = V_SEED + index_q * V_STEP;
  assign start_fire  = start__ENA && start__RDY;
  assign say_fire    = request_say__ENA;
  assign heard_fire  = indication_heard__ENA && indication_heard__RDY;
  assign heard_match = (indication_heard_meth == exp_meth_q) &&
                       (indication_heard_v == exp_v_q);
  assign last_req    = (index_q + 32'd1 == count_q);
  assign tmo_hit     = (timer_q == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      index_q    <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      exp_meth_q <= '0;
      exp_v_q    <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      exp_meth_q <= exp_meth_d;
      exp_v_q    <= exp_v_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_fire) state_d = (start_count == 32'd0) ? DONE : SEND;
      end
      SEND: begin
        if (say_fire) state_d = WAIT;
      end
      WAIT: begin
        // An indication arriving on the timeout cycle takes priority.
        if (heard_fire)   state_d = last_req ? DONE : SEND;
        else if (tmo_hit) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    index_d    = index_q;
    count_d    = count_q;
    timer_d    = timer_q;
    exp_meth_d = exp_meth_q;
    exp_v_d    = exp_v_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_fire) begin
          count_d = start_count;
          index_d = '0;
          pass_d  = '0;
          fail_d  = '0;
          tmo_d   = 1'b0;
          done_d  = (start_count == 32'd0);
        end
      end
      SEND: begin
        if (say_fire) begin
          exp_meth_d = index_q;
          exp_v_d    = v_cur;
          timer_d    = '0;
        end
      end
      WAIT: begin
        if (heard_fire) begin
          if (heard_match) pass_d = pass_q + 32'd1;
          else             fail_d = fail_q + 32'd1;
          if (last_req) done_d  = 1'b1;
          else          index_d = index_q + 32'd1;
        end else if (tmo_hit) begin
          tmo_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    start__RDY            = (state_q == IDLE) || (state_q == DONE);
    busy                  = (state_q == SEND) || (state_q == WAIT);
    rule_ready            = (state_q == SEND) && request_say__RDY;
    request_say__ENA      = rule_enable && rule_ready;
    request_say_meth      = (state_q == SEND) ? index_q : 32'd0;
    request_say_v         = (state_q == SEND) ? v_cur : 32'd0;
    indication_heard__RDY = (state_q == WAIT);
  end

  assign done       = done_q;
  assign timed_out  = tmo_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_echo_requester.sv
// Scoreboard bench for echo_requester: a behavioural responder answers each say,
// expected says and run statistics come from a plain arithmetic model.
`timescale 1ns/1ps
module tb_echo_requester;
  localparam int TMO = 8;
  localparam logic [31:0] SEED = 32'h1000;
  localparam logic [31:0] STEP = 32'h0101;

  logic        clk, nrst;
  logic        start_ena, start_rdy;
  logic [31:0] start_cnt;
  logic        say_ena, say_rdy;
  logic [31:0] say_meth, say_v;
  logic        heard_ena, heard_rdy;
  logic [31:0] heard_meth, heard_v;
  logic        rule_en, rule_ready, busy, done, timed_out;
  logic [31:0] pass_count, fail_count;

  logic        man_rdy, man_re, bp_en, bp_rdy, bp_re;
  logic        m_heard_ena, r_heard_ena;
  logic [31:0] m_meth, m_v, r_meth, r_v;

  assign say_rdy    = bp_en ? bp_rdy : man_rdy;
  assign rule_en    = bp_en ? bp_re  : man_re;
  assign heard_ena  = m_heard_ena | r_heard_ena;
  assign heard_meth = m_heard_ena ? m_meth : r_meth;
  assign heard_v    = m_heard_ena ? m_v    : r_v;

  echo_requester #(.TIMEOUT(TMO), .V_SEED(SEED), .V_STEP(STEP)) dut (
    .CLK(clk), .nRST(nrst),
    .start__ENA(start_ena), .start_count(start_cnt), .start__RDY(start_rdy),
    .request_say__ENA(say_ena), .request_say_meth(say_meth), .request_say_v(say_v),
    .request_say__RDY(say_rdy),
    .indication_heard__ENA(heard_ena), .indication_heard_meth(heard_meth),
    .indication_heard_v(heard_v), .indication_heard__RDY(heard_rdy),
    .rule_enable(rule_en), .rule_ready(rule_ready), .busy(busy), .done(done),
    .timed_out(timed_out), .pass_count(pass_count), .fail_count(fail_count)
  );

  typedef struct { logic [31:0] meth; logic [31:0] v; } req_t;
  req_t exp_q[$];

  int nvec = 0, nmis = 0, cyc = 0, says = 0, last_say_cyc = 0;
  int resp_lat = 3;
  logic [31:0] resp_mask = '0;
  bit resp_silent = 0, resp_busy = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bp_rdy = 0;
    bp_re  = 0;
    forever begin
      @(posedge clk);
      #1;
      bp_rdy = 1'($urandom_range(0, 1));
      bp_re  = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every say that will fire on the next edge is popped and compared.
  initial forever begin
    req_t r;
    @(negedge clk);
    if (nrst && say_ena) begin
      says++;
      last_say_cyc = cyc;
      chk1("say_guard", rule_en & say_rdy, 1'b1);
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL say_unexpected: got meth 0x%0h v 0x%0h, expected no request", say_meth, say_v);
      end else begin
        r = exp_q.pop_front();
        chk("say_meth", say_meth, r.meth);
        chk("say_v", say_v, r.v);
      end
    end
  end

  // Responder: echoes meth/v resp_lat edges after the say, optionally corrupting v.
  initial begin
    logic [31:0] m, v;
    r_heard_ena = 0;
    r_meth = 0;
    r_v = 0;
    forever begin
      @(negedge clk);
      if (nrst && say_ena && !resp_silent) begin
        resp_busy = 1;
        m = say_meth;
        v = say_v;
        if (m < 32 && resp_mask[m[4:0]]) v = v ^ 32'd1;
        repeat (resp_lat) @(posedge clk);
        #1;
        r_heard_ena = 1;
        r_meth = m;
        r_v = v;
        @(posedge clk);
        #1;
        r_heard_ena = 0;
        resp_busy = 0;
      end
    end
  end

  task automatic check_cleared(input string p);
    chk1({p, "_start_rdy"}, start_rdy, 1'b1);
    chk1({p, "_say_ena"}, say_ena, 1'b0);
    chk({p, "_say_meth"}, say_meth, 32'd0);
    chk({p, "_say_v"}, say_v, 32'd0);
    chk1({p, "_heard_rdy"}, heard_rdy, 1'b0);
    chk1({p, "_rule_ready"}, rule_ready, 1'b0);
    chk1({p, "_busy"}, busy, 1'b0);
    chk1({p, "_done"}, done, 1'b0);
    chk1({p, "_timed_out"}, timed_out, 1'b0);
    chk({p, "_pass"}, pass_count, 32'd0);
    chk({p, "_fail"}, fail_count, 32'd0);
  endtask

  task automatic push_says(input int k);
    for (int i = 0; i < k; i++) begin
      req_t r;
      r.meth = 32'(i);
      r.v    = SEED + 32'(i) * STEP;
      exp_q.push_back(r);
    end
  endtask

  task automatic do_start(input int n);
    int k = 0;
    while (!start_rdy && k < 200) begin
      tick();
      k++;
    end
    if (!start_rdy) begin
      nvec++;
      nmis++;
      $display("FAIL start_wait: got start__RDY=0 after 200 cycles, expected 1");
    end
    start_ena = 1;
    start_cnt = 32'(n);
    tick();
    start_ena = 0;
  endtask

  task automatic wait_resp_idle();
    int k = 0;
    while (resp_busy && k < 50) begin
      tick();
      k++;
    end
  endtask

  task automatic run(input int n, input int lat, input logic [31:0] mask,
                     input bit silent, input bit poke);
    int ep = 0, ef = 0, nsay, k = 0, budget;
    bit etmo;
    resp_lat = lat;
    resp_mask = mask;
    resp_silent = silent;
    etmo = (n > 0) && (silent || lat > TMO);
    nsay = etmo ? 1 : n;
    if (!etmo)
      for (int i = 0; i < n; i++)
        if (i < 32 && mask[i]) ef++; else ep++;
    push_says(nsay);
    do_start(n);
    if (poke) begin
      while (!heard_rdy && k < 200) begin
        tick();
        k++;
      end
      start_ena = 1;
      start_cnt = 32'd7;
      chk1("poke_start_rdy", start_rdy, 1'b0);
      tick();
      start_ena = 0;
    end
    budget = n * 60 + TMO + 40;
    k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n == 0) chk("zero_latency", 32'(k), 32'd0);
    chk1("run_done", done, 1'b1);
    chk1("run_busy", busy, 1'b0);
    chk1("run_timed_out", timed_out, etmo);
    chk("run_pass", pass_count, 32'(ep));
    chk("run_fail", fail_count, 32'(ef));
    chk("run_says_left", 32'(exp_q.size()), 32'd0);
    if (etmo) chk("timeout_cycles", 32'(cyc - last_say_cyc), 32'(TMO + 1));
    wait_resp_idle();
    repeat (3) tick();
    @(negedge clk);
    chk("late_pass", pass_count, 32'(ep));
    chk("late_fail", fail_count, 32'(ef));
    exp_q.delete();
  endtask

  task automatic guard(input bit use_re);
    int k = 0;
    resp_lat = 3;
    resp_mask = '0;
    resp_silent = 0;
    push_says(1);
    if (use_re) man_re = 0; else man_rdy = 0;
    do_start(1);
    repeat (5) begin
      @(negedge clk);
      chk1("guard_rule_ready", rule_ready, use_re);
      chk1("guard_no_say", say_ena, 1'b0);
    end
    tick();
    man_re = 1;
    man_rdy = 1;
    @(negedge clk);
    chk1("guard_first_cycle", say_ena, 1'b1);
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk1("guard_done", done, 1'b1);
    chk("guard_pass", pass_count, 32'd1);
    chk("guard_says_left", 32'(exp_q.size()), 32'd0);
    wait_resp_idle();
    exp_q.delete();
  endtask

  task automatic reset_mid_run();
    int base, k = 0;
    resp_lat = 5;
    resp_mask = '0;
    resp_silent = 0;
    push_says(3);
    base = says;
    do_start(3);
    while (says < base + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    tick();
    chk1("rst_in_wait", heard_rdy, 1'b1);
    chk("rst_pre_pass", pass_count, 32'd1);
    nrst = 0;
    tick();
    nrst = 1;
    @(negedge clk);
    check_cleared("rst_mid");
    exp_q.delete();
    wait_resp_idle();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_late_pass", pass_count, 32'd0);
    tick();
    run(1, 3, 32'd0, 0, 0);
  endtask

  initial begin
    nrst = 0;
    start_ena = 0;
    start_cnt = 0;
    man_rdy = 1;
    man_re = 1;
    bp_en = 0;
    m_heard_ena = 0;
    m_meth = 0;
    m_v = 0;
    repeat (2) tick();
    @(negedge clk);
    check_cleared("reset");
    tick();
    nrst = 1;
    @(negedge clk);
    check_cleared("idle");

    // Indication offered in IDLE must be refused and leave stats untouched.
    tick();
    m_heard_ena = 1;
    m_meth = 32'd0;
    m_v = SEED;
    @(negedge clk);
    chk1("idle_heard_rdy", heard_rdy, 1'b0);
    tick();
    m_heard_ena = 0;
    @(negedge clk);
    check_cleared("idle_heard");

    run(4, 3, 32'h0, 0, 0);
    run(4, 3, 32'h4, 0, 0);
    run(2, 1, 32'h0, 1, 0);
    run(0, 3, 32'h0, 0, 0);
    guard(1);
    guard(0);
    run(2, 6, 32'h0, 0, 1);
    run(1, TMO, 32'h0, 0, 0);
    run(2, TMO + 1, 32'h0, 0, 0);
    reset_mid_run();

    bp_en = 1;
    for (int it = 0; it < 6; it++)
      run($urandom_range(1, 10), $urandom_range(1, 7), $urandom, 0, 0);
    bp_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/echo_requester.md
Name: echo_requester

Overview:
- Initiator side of the echo request/indication protocol: issues numbered say requests (meth, v) to an echo responder and consumes the returned heard indications.
- Checks each indication against the request it answers and keeps pass, fail and timeout statistics.
- Sits in the test/bring-up harness, wired port-for-port to an echo responder's request$say and indication$heard interfaces.
- Only one request is outstanding at a time.

Parameters:
TIMEOUT, 1024, cycles to wait in WAIT for indication$heard before aborting (≥2)
V_SEED, 32'h1000, v value of request index 0
V_STEP, 32'h0101, v increment per request index, modulo 2^32

Ports:
CLK  input  1  clock
nRST  input  1  reset, synchronous, active-low
start__ENA  input  1  begin a run
start_count  input  32  number of requests in the run
start__RDY  output  1  start is accepted
request$say__ENA  output  1  issue say request
request$say_meth  output  32  request meth field
request$say_v  output  32  request v field
request$say__RDY  input  1  responder can accept a say
indication$heard__ENA  input  1  responder delivers an indication
indication$heard_meth  input  32  indication meth field
indication$heard_v  input  32  indication v field
indication$heard__RDY  output  1  requester can accept an indication
rule_enable  input  1  scheduler enable for send_rule
rule_ready  output  1  send_rule guard
busy  output  1  run in progress
done  output  1  last run finished
timed_out  output  1  last run aborted on timeout
pass_count  output  32  indications that matched their request
fail_count  output  32  indications that mismatched their request

Behaviour:
- Internal enable of every method/rule = external ENA && its own RDY. An ENA presented while RDY=0 is ignored with no state effect.
- Reset (nRST=0 at posedge): state=IDLE; index, count, timer, exp_meth, exp_v, pass_count, fail_count = 0; done=0; timed_out=0. All outputs therefore read 0 except start__RDY=1.
- States: IDLE=0, SEND=1, WAIT=2, DONE=3. busy = (state==SEND || state==WAIT).
- start__RDY = (state==IDLE || state==DONE).
- start fire:
  - Latch count=start_count; clear index, pass_count, fail_count, timed_out and done.
  - If start_count==0: go to DONE with done=1. Otherwise go to SEND.
- SEND:
  - rule_ready = (state==SEND) && request$say__RDY.
  - request$say__ENA = rule_enable && rule_ready.
  - request$say_meth = index; request$say_v = V_SEED + index*V_STEP, truncated to 32 bits. Both are combinational from index and are valid whenever state==SEND.
  - On fire: exp_meth/exp_v take the sent values; timer=0; go to WAIT. Latency from request to indication is set entirely by the responder.
- WAIT:
  - indication$heard__RDY = (state==WAIT).
  - On heard fire: if heard_meth==exp_meth && heard_v==exp_v then pass_count+1, else fail_count+1.
  - After the check: if index+1==count, go to DONE with done=1; else index+1 and go to SEND. The next request issues no earlier than the following cycle.
  - Without heard: timer+1 each cycle. When timer==TIMEOUT-1: timed_out=1, done=1, go to DONE; pass_count/fail_count unchanged.
  - heard fire in the same cycle as the timeout condition: heard wins and no timeout is raised.
- DONE: stats hold until the next start or reset. heard__RDY=0, so a late indication is not accepted and is not counted.
- Counter wrap: pass_count and fail_count wrap modulo 2^32. index never exceeds count-1.
- Reset mid-run: abandons the run immediately, returns to IDLE, clears all stats. An in-flight responder transaction is the responder's concern.
- start arriving while busy: start__RDY=0, so it is ignored.

Test Plan:
- Ideal responder (say__RDY=1, heard echoes meth/v 3 cycles later), start_count=4, rule_enable=1 → say v = 0x1000, 0x1101, 0x1202, 0x1303 with meth 0..3; pass_count=4, fail_count=0, done=1, busy=0.
- Responder corrupts v of index 2 (xor 1) with start_count=4 → pass_count=3, fail_count=1, timed_out=0.
- Responder never sends heard, TIMEOUT=8, start_count=2 → say issued once; exactly 8 cycles later timed_out=1 and done=1; pass_count=0, fail_count=0.
- rule_enable=0 for 5 cycles, then 1, and separately say__RDY=0 for 5 cycles → no say__ENA while either is low; the request issues on the first cycle both are high; values are unchanged.
- Edge and guard cases:
  - start_count=0 → DONE on the next cycle with all stats 0.
  - heard__ENA pulsed in IDLE → ignored.
  - start__ENA pulsed during WAIT → ignored.
  - heard and timeout in the same cycle → counted as a pass, timed_out=0.
- nRST low for 1 cycle mid-run (index=1, in WAIT) → IDLE, all outputs 0, start__RDY=1; a fresh start with start_count=1 then passes normally.
